// File: rtl/index_to_mask.sv
// Rebuilds a DATA_WIDTH-bit word from a stream of bit-index beats, one frame per result.
// Tracks distinct-bit count plus duplicate and out-of-range error flags.
module index_to_mask #(
  parameter  int DATA_WIDTH = 32,
  localparam int IW         = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [IW-1:0]         din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [IW-1:0]         dout_cnt,
  output logic                  dout_dup,
  output logic                  dout_err,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam logic [IW-1:0]         DW_IDX  = IW'(DATA_WIDTH);
  localparam logic [IW-1:0]         CNT_ONE = IW'(1);
  localparam logic [DATA_WIDTH-1:0] BIT0    = DATA_WIDTH'(1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [IW-1:0]         cnt_q;
  logic                  dup_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] onehot;
  logic                  in_range;
  logic                  over;
  logic                  hit;

  // Index DATA_WIDTH is the "no bit" sentinel: neither in range nor an error.
  assign in_range = (din < DW_IDX);
  assign over     = (din > DW_IDX);
  assign onehot   = in_range ? (BIT0 << din) : '0;
  assign hit      = |(mask_q & onehot);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= COLLECT;
      mask_q  <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (din_valid) begin
            if (in_range) begin
              // A repeated index flags dup but must not inflate the count.
              if (hit) begin
                dup_q <= 1'b1;
              end else begin
                mask_q <= mask_q | onehot;
                cnt_q  <= cnt_q + CNT_ONE;
              end
            end else if (over) begin
              err_q <= 1'b1;
            end
            if (din_last) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (dout_ready) begin
            mask_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign din_ready  = (state_q == COLLECT);
  assign dout_valid = (state_q == HOLD);
  assign dout       = mask_q;
  assign dout_cnt   = cnt_q;
  assign dout_dup   = dup_q;
  assign dout_err   = err_q;

endmodule

// File: doc/index_to_mask.md
# index_to_mask

Sequential frame-level mask builder; the inverse of the trailing-zero counter. Accepts a stream of bit-index beats (same width and encoding as trailing-zero counter output, where value DATA_WIDTH means "no bit") over a valid/ready handshake. Accumulates one DATA_WIDTH-bit mask per frame and presents it with a distinct-bit count and error flags on a valid/ready output port. It sits downstream of a set-bit iterator that emits indices lowest-first, and rebuilds the original word.

## Interface
- DATA_WIDTH, 32: mask width; index width is $clog2(DATA_WIDTH)+1
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- din  input  $clog2(DATA_WIDTH)+1  bit index beat
- din_valid  input  1  beat valid
- din_last  input  1  beat is final beat of frame; qualified by din_valid
- din_ready  output  1  block can accept a beat
- dout  output  DATA_WIDTH  accumulated mask
- dout_cnt  output  $clog2(DATA_WIDTH)+1  number of set bits in dout
- dout_dup  output  1  frame contained a repeated in-range index
- dout_err  output  1  frame contained an index > DATA_WIDTH
- dout_valid  output  1  dout/dout_cnt/dout_dup/dout_err valid
- dout_ready  input  1  consumer accepts result

## Operation
- Two states: COLLECT (din_ready=1, dout_valid=0) and HOLD (din_ready=0, dout_valid=1).
- Beat accepted when din_valid && din_ready at a rising edge.
- Accepted index i < DATA_WIDTH: set mask bit i; if bit i already set, set dup flag and leave dout_cnt unchanged, else dout_cnt += 1.
- Accepted index == DATA_WIDTH: sentinel for empty word; mask and count unchanged, no flag.
- Accepted index > DATA_WIDTH (only possible when DATA_WIDTH not a power of two, or index MSB set with nonzero low bits): set err flag; mask and count unchanged.
- Accepted beat with din_last=1: apply the beat as above, then transition COLLECT -> HOLD. Frames may be a single beat.
- HOLD: dout, dout_cnt, dout_dup, dout_err held stable while dout_valid=1 and dout_ready=0.
- dout_valid && dout_ready at an edge: clear mask, count, dup, err; transition HOLD -> COLLECT.
- din_valid while in HOLD: ignored (not accepted, no state change); upstream must hold the beat.
- dout_cnt never exceeds DATA_WIDTH; popcount of dout always equals dout_cnt.
- dout, dout_cnt, dout_dup, dout_err are the running accumulators; they are meaningful only when dout_valid=1.

## Timing
- Reset (resetn=0, asynchronous, takes effect immediately): state COLLECT, din_ready=1, dout_valid=0, dout=0, dout_cnt=0, dout_dup=0, dout_err=0. Reset mid-frame discards partial frame; reset in HOLD drops pending result.
- Deassertion of resetn is treated as synchronous to clk by the surrounding design.
- Latency: last beat accepted at edge N -> dout_valid=1 and final dout visible after edge N (same cycle the last beat's effect appears).
- Throughput: one beat per cycle in COLLECT. One-cycle bubble per frame minimum: result handshake at edge M -> din_ready=1 after edge M, next beat accepted at edge M+1 earliest.
- din_ready is a pure function of state (no combinational path from din_valid or dout_ready).
- dout_valid is a registered state output; no combinational path from any input.

## Test plan
- Reset: hold resetn=0 mid-frame after beats 3,5 -> immediately dout=0, dout_cnt=0, flags 0, dout_valid=0, din_ready=1; next frame starts clean.
- Multi-beat frame: beats 0,4,31(last), dout_ready=1 -> dout=0x80000011, dout_cnt=3, dup=0, err=0, dout_valid one cycle, din_ready=1 the following cycle.
- Empty frame: single beat 32 with last -> dout=0, dout_cnt=0, dup=0, err=0, dout_valid=1.
- Duplicate: beats 7,7,2(last) -> dout=0x00000084, dout_cnt=2, dup=1.
- Error (DATA_WIDTH=24, index width 6): beats 30,1(last) -> dout=0x000002, dout_cnt=1, err=1; beat 24 alone -> dout=0, err=0.
- Backpressure: frame 9(last) with dout_ready=0 for 5 cycles while din_valid=1 with index 3 -> dout=0x00000200 stable, din_ready=0, index 3 not accepted; after dout_ready=1 handshake, index 3 accepted next cycle into fresh frame.
